// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the edge-counting frequency meter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Cycles spent flushing the synchronizer before a window may open.
  localparam int SETTLE_CYCLES = 2;

  // Flops between the asynchronous pin and the first usable sample.
  localparam int SYNC_STAGES = 2;

  // Bits needed to count 0 .. cycles-1 (never narrower than one bit).
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Synchronizes the asynchronous input and flags its rising edges.
// Latency: a pin rise shows up on rise ~3 clk cycles later (+/-1 from metastability).
// Backpressure: none; rise is a free-running one-cycle pulse.
module freq_meter_edge_sync
  import freq_meter_pkg::*;
(
  input  logic CLK,
  input  logic RESETN,
  input  logic I,
  output logic rise
);

  // sr[0], sr[1] form the synchronizer; sr[2] is the delayed copy for edge detect.
  logic [SYNC_STAGES:0] sr;

  // Shift the pin through the synchronizer and the edge-detect flop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-1:0], I};
    end
  end

  assign rise = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of I over GATE_CYCLES-clock windows; FREQ_METER_PERIOD_EN adds edge-to-edge period output.
// Latency: O/OVF/VALID register one cycle after the closing gate cycle; first VALID GATE_CYCLES+3 cycles after EN rises.
// Backpressure: none; VALID/PVALID are one-cycle strobes, O/OVF/PERIOD hold until the next update.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 12000000,
  parameter int COUNT_W     = 26
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               EN,
  input  logic               I,
  output logic [COUNT_W-1:0] O,
  output logic               VALID,
  output logic               OVF
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [COUNT_W-1:0] PERIOD,
  output logic               PVALID
`endif
);

  localparam int GW = gate_w(GATE_CYCLES);
  localparam int SW = gate_w(SETTLE_CYCLES);
  localparam logic [GW-1:0]      GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = {COUNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic               settle_done;
  logic               win_close;
  logic               measuring;
  logic               rise;
  logic [SW-1:0]      settle_cnt;
  logic [GW-1:0]      gate;
  logic [COUNT_W-1:0] edge_cnt;
  logic               sat;
  logic               cnt_at_max;
  logic [COUNT_W-1:0] cnt_inc;
  logic               ovf_hit;

  freq_meter_edge_sync u_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .I      (I),
    .rise   (rise)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; dropping EN always wins, including over a window close.
  always_comb begin
    state_nxt   = state;
    settle_done = 1'b0;
    win_close   = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SETTLE;
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt   = MEASURE;
            settle_done = 1'b1;
          end
        end
        MEASURE: begin
          if (gate == GATE_LAST) begin
            win_close = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign measuring  = EN && (state == MEASURE);
  assign cnt_at_max = (edge_cnt == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? edge_cnt : edge_cnt + {{(COUNT_W-1){1'b0}}, rise};
  // Overflow means an edge arrived with nowhere left to count it.
  assign ovf_hit    = sat | (cnt_at_max & rise);

  // Settle timer: runs only while settling with EN held.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      settle_cnt <= '0;
    end else if (EN && (state == SETTLE) && !settle_done) begin
      settle_cnt <= settle_cnt + SW'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Gate and edge counters; restart together at window close with no dead cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      gate     <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (!measuring || win_close) begin
      gate     <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      gate     <= gate + GW'(1);
      edge_cnt <= cnt_inc;
      sat      <= ovf_hit;
    end
  end

  // Latch the closing window's count (including its last-cycle edge) and strobe VALID.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      O     <= '0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else begin
      VALID <= win_close;
      if (win_close) begin
        O   <= cnt_inc;
        OVF <= ovf_hit;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [COUNT_W-1:0] per_cnt;
  logic               per_armed;

  // Period counter: first edge in a measurement run only arms it, later edges report the gap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      per_cnt   <= '0;
      per_armed <= 1'b0;
      PERIOD    <= '0;
      PVALID    <= 1'b0;
    end else begin
      PVALID <= 1'b0;
      if (!measuring) begin
        per_cnt   <= '0;
        per_armed <= 1'b0;
      end else if (rise) begin
        if (per_armed) begin
          PERIOD <= per_cnt;
          PVALID <= 1'b1;
        end
        per_cnt   <= COUNT_W'(1);
        per_armed <= 1'b1;
      end else if (per_armed && (per_cnt != CNT_MAX)) begin
        per_cnt <= per_cnt + COUNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (COUNT_W=8 and COUNT_W=3) share one stimulus stream.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_freq_meter;

  localparam int G = 16;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  logic EN     = 1'b0;
  logic I      = 1'b0;

  logic [7:0] o8;
  logic       v8;
  logic       ovf8;
  logic [2:0] o3;
  logic       v3;
  logic       ovf3;
`ifdef FREQ_METER_PERIOD_EN
  logic [7:0] per8;
  logic       pv8;
  logic [2:0] per3;
  logic       pv3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(8)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (EN),
    .I      (I),
    .O      (o8),
    .VALID  (v8),
    .OVF    (ovf8)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .PERIOD (per8),
    .PVALID (pv8)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(3)) dut_sat (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (EN),
    .I      (I),
    .O      (o3),
    .VALID  (v3),
    .OVF    (ovf3)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .PERIOD (per3),
    .PVALID (pv3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // run = number of consecutive clock edges that sampled EN=1 since IDLE.
  // A cycle whose preceding edge had run>=3 is a measuring cycle; its gate index is (run-3)%G.
  int run   = 0;
  int acc   = 0;
  int pc    = 0;
  bit armed = 1'b0;
  bit h0    = 1'b0;
  bit h1    = 1'b0;
  bit h2    = 1'b0;
  bit e_cur = 1'b0;
  int m_valid = 0;
  int m_o8    = 0;
  int m_ovf8  = 0;
  int m_o3    = 0;
  int m_ovf3  = 0;
  int m_pv    = 0;
  int m_per8  = 0;
  int m_per3  = 0;

  initial forever begin
    @(posedge CLK or negedge RESETN);
    if (!RESETN) begin
      run = 0; acc = 0; pc = 0; armed = 1'b0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      m_valid = 0; m_o8 = 0; m_ovf8 = 0; m_o3 = 0; m_ovf3 = 0;
      m_pv = 0; m_per8 = 0; m_per3 = 0;
    end else begin
      // Edge seen during the cycle that just ended: pin sampled high two edges back, low three back.
      e_cur   = h1 && !h2;
      m_valid = 0;
      m_pv    = 0;
      if (EN) begin
        if (run >= 3) begin
          if (e_cur) acc++;
          if ((run - 3) % G == G - 1) begin
            m_valid = 1;
            m_o8    = (acc > 255) ? 255 : acc;
            m_ovf8  = (acc > 255) ? 1 : 0;
            m_o3    = (acc > 7) ? 7 : acc;
            m_ovf3  = (acc > 7) ? 1 : 0;
            acc     = 0;
          end
          if (e_cur) begin
            if (armed) begin
              m_pv   = 1;
              m_per8 = (pc > 255) ? 255 : pc;
              m_per3 = (pc > 7) ? 7 : pc;
            end
            pc    = 1;
            armed = 1'b1;
          end else if (armed) begin
            pc++;
          end
        end else begin
          armed = 1'b0;
          pc    = 0;
        end
        run++;
      end else begin
        run   = 0;
        acc   = 0;
        armed = 1'b0;
        pc    = 0;
      end
      h2 = h1;
      h1 = h0;
      h0 = I;
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge CLK);
    chk("valid8", 32'(v8), m_valid);
    chk("o8", 32'(o8), m_o8);
    chk("ovf8", 32'(ovf8), m_ovf8);
    chk("valid3", 32'(v3), m_valid);
    chk("o3", 32'(o3), m_o3);
    chk("ovf3", 32'(ovf3), m_ovf3);
`ifdef FREQ_METER_PERIOD_EN
    chk("pvalid8", 32'(pv8), m_pv);
    chk("period8", 32'(per8), m_per8);
    chk("pvalid3", 32'(pv3), m_pv);
    chk("period3", 32'(per3), m_per3);
`endif
  end

  // ---------------- input pin generator ----------------
  // mode 0: static level, 1: toggle every 'half' cycles, 2: random each cycle, 3: sparse random toggles
  int mode = 0;
  int half = 2;
  bit lvl  = 1'b0;
  int ph   = 0;

  initial forever begin
    @(posedge CLK);
    #1;
    case (mode)
      0: I = lvl;
      1: begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          I  = ~I;
        end
      end
      2: I = 1'($urandom_range(0, 1));
      default: if ($urandom_range(0, 7) == 0) I = ~I;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Cycles until VALID is seen (0 if it never arrives within the budget).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK);
      #1;
      if (v8 === 1'b1) begin
        cyc = k;
        return;
      end
    end
  endtask

`ifdef FREQ_METER_PERIOD_EN
  task automatic wait_pvalid(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK);
      #1;
      if (pv8 === 1'b1) begin
        cyc = k;
        return;
      end
    end
  endtask
`endif

  int c;
  int nv;

  initial begin
    RESETN = 1'b0;
    EN     = 1'b0;
    tick(3);
    #2;
    chk("reset_o", 32'(o8), 0);
    chk("reset_valid", 32'(v8), 0);
    chk("reset_ovf", 32'(ovf8), 0);
    RESETN = 1'b1;

    // Period-4 square wave: 4 edges per 16-cycle window, first VALID 19 cycles after EN.
    mode = 1;
    half = 2;
    tick(4);
    EN = 1'b1;
    wait_valid(c);
    chk("first_valid_latency", c, 19);
    chk("o_period4", 32'(o8), 4);
    chk("ovf_period4", 32'(ovf8), 0);
    wait_valid(c);
    chk("valid_spacing", c, 16);
    chk("o_period4_b", 32'(o8), 4);

    // Drop EN at gate=10: window discarded, O holds.
    tick(10);
    EN = 1'b0;
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (v8 === 1'b1) nv++;
    end
    chk("en_drop_no_valid", nv, 0);
    chk("en_drop_hold_o", 32'(o8), 4);
    EN = 1'b1;
    wait_valid(c);
    chk("reenable_latency", c, 19);
    chk("reenable_o", 32'(o8), 4);

    // Static high then static low.
    mode = 0;
    lvl  = 1'b1;
    tick(40);
    wait_valid(c);
    chk("static_high_seen", 32'(c != 0), 1);
    chk("static_high_o", 32'(o8), 0);
    lvl = 1'b0;
    tick(40);
    wait_valid(c);
    chk("static_low_o", 32'(o8), 0);

    // Toggle every clock: 8 edges per window, saturates the 3-bit instance.
    mode = 1;
    half = 1;
    tick(20);
    wait_valid(c);
    wait_valid(c);
    chk("sat_o3", 32'(o3), 7);
    chk("sat_ovf3", 32'(ovf3), 1);
    chk("nosat_o8", 32'(o8), 8);
    chk("nosat_ovf8", 32'(ovf8), 0);

    // Reset mid-window clears outputs without waiting for a clock edge.
    half = 2;
    tick(20);
    wait_valid(c);
    tick(9);
    RESETN = 1'b0;
    #2;
    chk("async_reset_o", 32'(o8), 0);
    chk("async_reset_o3", 32'(o3), 0);
    chk("async_reset_valid", 32'(v8), 0);
    chk("async_reset_ovf", 32'(ovf8), 0);
    tick(2);
    RESETN = 1'b1;
    wait_valid(c);
    chk("post_reset_latency", c, 19);
    chk("post_reset_o", 32'(o8), 4);

    // Period-6 input.
    half = 3;
    EN   = 1'b0;
    tick(2);
    EN = 1'b1;
`ifdef FREQ_METER_PERIOD_EN
    wait_pvalid(c);
    chk("first_pvalid_seen", 32'(c != 0), 1);
    chk("period6", 32'(per8), 6);
    wait_pvalid(c);
    chk("pvalid_spacing", c, 6);
    chk("period6_b", 32'(per8), 6);
`else
    tick(60);
`endif

    // Randomized traffic with random enable drops and occasional resets.
    mode = 2;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) mode = 3;
      tick(1);
      if ($urandom_range(0, 99) == 0) EN = ~EN;
      if ($urandom_range(0, 499) == 0) begin
        RESETN = 1'b0;
        tick(1);
        RESETN = 1'b1;
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
